ara_eoc_monitor: RTL and testbench

Synthesizable end-of-computation monitor for multi-core Ara test harnesses. It watches one tohost word per channel and measures run length in clock cycles. It resolves the pass/fail verdict in hardware, with deterministic priority, and an optional watchdog can force a timeout verdict. The harness instantiates it next to the DUT. The verilator top only reads its registered outputs to print the cycle count and call `$finish`.

---
 rtl/ara_eoc_monitor.sv | 190 +++++++++++++++++++
 tb/tb_ara_eoc_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ara_eoc_monitor.sv
// ara_eoc_monitor: end-of-computation monitor for multi-core Ara harnesses.
// Watches one tohost word per channel, counts RUN cycles and resolves a
// registered pass/fail verdict with fixed priority:
//   nonzero code (lowest channel first) > all channels passed > timeout.
// Optional watchdog: define ARA_EOC_WATCHDOG_EN to enable the timeout path.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         start a measurement (IDLE only)
//   clear_i         synchronous return to IDLE, wins over start_i
//   exit_i          per channel 64-bit word: bit 0 valid, [63:1] exit code
//   done_o          verdict available
//   pass_o, fail_o  exclusive verdict in DONE
//   timeout_o       watchdog expired (implies fail_o)
//   exit_code_o     code of the failing channel (0 on pass/timeout)
//   fail_chan_o     index of the failing channel
//   chan_done_o     sticky per-channel exit flags
//   cycles_o        saturating count of cycles spent in RUN
module ara_eoc_monitor #(
  parameter int unsigned  NrChannels    = 1,
  parameter int unsigned  CntWidth      = 64,
  parameter logic [31:0]  TimeoutCycles = 32'd1_000_000,
  localparam int unsigned ChanW         = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [NrChannels*64-1:0] exit_i,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [62:0]              exit_code_o,
  output logic [ChanW-1:0]         fail_chan_o,
  output logic [NrChannels-1:0]    chan_done_o,
  output logic [CntWidth-1:0]      cycles_o
);

  localparam int unsigned CodeW = 63;
  // Watchdog compare width wide enough that neither operand gets truncated.
  localparam int unsigned CmpW  = (CntWidth > 32) ? CntWidth : 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic [CodeW-1:0]      code_q, code_d;
  logic [ChanW-1:0]      fchan_q, fchan_d;
  logic [NrChannels-1:0] chan_done_q, chan_done_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic                  wd_expire;
  logic [NrChannels-1:0] new_valid;
  logic                  hit;
  logic [CodeW-1:0]      hit_code;
  logic [ChanW-1:0]      hit_chan;

`ifdef ARA_EOC_WATCHDOG_EN
  // Expiry on the edge whose pre-increment count is TimeoutCycles-1.
  assign wd_expire = (CmpW'(cnt_q) == CmpW'(TimeoutCycles - 32'd1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
  assign wd_expire      = 1'b0;
`endif

  // First valid cycle of each channel; already-exited channels are ignored.
  always_comb begin
    new_valid = '0;
    hit       = 1'b0;
    hit_code  = '0;
    hit_chan  = '0;
    for (int c = 0; c < NrChannels; c++) begin
      new_valid[c] = exit_i[64*c] & ~chan_done_q[c];
    end
    // Scan downward so the lowest failing channel wins.
    for (int c = NrChannels - 1; c >= 0; c--) begin
      if (new_valid[c] && (exit_i[64*c+1 +: CodeW] != '0)) begin
        hit      = 1'b1;
        hit_code = exit_i[64*c+1 +: CodeW];
        hit_chan = ChanW'(c);
      end
    end
  end

  // Next-state and verdict logic.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    code_d      = code_q;
    fchan_d     = fchan_q;
    chan_done_d = chan_done_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          timeout_d   = 1'b0;
          code_d      = '0;
          fchan_d     = '0;
          chan_done_d = '0;
          cnt_d       = '0;
        end
      end
      StRun: begin
        cnt_d       = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + CntWidth'(1);
        chan_done_d = chan_done_q | new_valid;
        if (hit) begin
          state_d = StDone;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          code_d  = hit_code;
          fchan_d = hit_chan;
        end else if (&chan_done_d) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (wd_expire) begin
          state_d   = StDone;
          done_d    = 1'b1;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase

    if (clear_i) begin
      state_d     = StIdle;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      code_d      = '0;
      fchan_d     = '0;
      chan_done_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      code_q      <= '0;
      fchan_q     <= '0;
      chan_done_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      code_q      <= code_d;
      fchan_q     <= fchan_d;
      chan_done_q <= chan_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign exit_code_o = code_q;
  assign fail_chan_o = fchan_q;
  assign chan_done_o = chan_done_q;
  assign cycles_o    = cnt_q;

endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Bench for ara_eoc_monitor: three instances (1 channel, 4 channels,
// 1 channel with a 4-bit counter). Expected verdicts are queued when the
// stimulus is issued and checked by per-instance monitors on done_o rising.
module tb_ara_eoc_monitor;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [62:0] code;
    logic [3:0]  chan;
    logic [3:0]  cdone;
    logic [63:0] cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 1: one channel, 64-bit counter, watchdog limit 20.
  logic        s1 = 0, c1 = 0;
  logic [63:0] e1 = '0;
  logic        d1, p1, f1, t1;
  logic [62:0] code1;
  logic [0:0]  fc1, cd1;
  logic [63:0] cy1;

  // Instance 4: four channels.
  logic         s4 = 0, c4 = 0;
  logic [255:0] e4 = '0;
  logic         d4, p4, f4, t4;
  logic [62:0]  code4;
  logic [1:0]   fc4;
  logic [3:0]   cd4;
  logic [63:0]  cy4;

  // Instance s: one channel, 4-bit saturating counter.
  logic        ss = 0, cs = 0;
  logic [63:0] es = '0;
  logic        ds, ps, fs, ts;
  logic [62:0] codes;
  logic [0:0]  fcs, cds;
  logic [3:0]  cys;

  ara_eoc_monitor #(.NrChannels(1), .CntWidth(64), .TimeoutCycles(32'd20)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s1), .clear_i(c1), .exit_i(e1),
    .done_o(d1), .pass_o(p1), .fail_o(f1), .timeout_o(t1), .exit_code_o(code1),
    .fail_chan_o(fc1), .chan_done_o(cd1), .cycles_o(cy1));

  ara_eoc_monitor #(.NrChannels(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s4), .clear_i(c4), .exit_i(e4),
    .done_o(d4), .pass_o(p4), .fail_o(f4), .timeout_o(t4), .exit_code_o(code4),
    .fail_chan_o(fc4), .chan_done_o(cd4), .cycles_o(cy4));

  ara_eoc_monitor #(.NrChannels(1), .CntWidth(4)) us (
    .clk_i(clk), .rst_ni(rst_n), .start_i(ss), .clear_i(cs), .exit_i(es),
    .done_o(ds), .pass_o(ps), .fail_o(fs), .timeout_o(ts), .exit_code_o(codes),
    .fail_chan_o(fcs), .chan_done_o(cds), .cycles_o(cys));

  exp_t q1[$], q4[$], qs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_verdict(input string name, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got p=%0b f=%0b t=%0b code=%0h chan=%0d cdone=%b cyc=%0d expected p=%0b f=%0b t=%0b code=%0h chan=%0d cdone=%b cyc=%0d",
               name, act.pass, act.fail, act.tmo, act.code, act.chan, act.cdone, act.cycles,
               exp.pass, exp.fail, exp.tmo, exp.code, exp.chan, exp.cdone, exp.cycles);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: done_o rose with no expected verdict queued", name);
  endtask

  // Monitors: compare on each rising done_o.
  logic pd1 = 0, pd4 = 0, pds = 0;
  always @(negedge clk) begin
    exp_t act;
    if (rst_n && d1 && !pd1) begin
      act = '{pass: p1, fail: f1, tmo: t1, code: code1, chan: 4'(fc1), cdone: 4'(cd1), cycles: cy1};
      if (q1.size() == 0) unexpected("u1_verdict");
      else cmp_verdict("u1_verdict", act, q1.pop_front());
    end
    if (rst_n && d4 && !pd4) begin
      act = '{pass: p4, fail: f4, tmo: t4, code: code4, chan: 4'(fc4), cdone: cd4, cycles: cy4};
      if (q4.size() == 0) unexpected("u4_verdict");
      else cmp_verdict("u4_verdict", act, q4.pop_front());
    end
    if (rst_n && ds && !pds) begin
      act = '{pass: ps, fail: fs, tmo: ts, code: codes, chan: 4'(fcs), cdone: 4'(cds), cycles: 64'(cys)};
      if (qs.size() == 0) unexpected("us_verdict");
      else cmp_verdict("us_verdict", act, qs.pop_front());
    end
    pd1 = d1;
    pd4 = d4;
    pds = ds;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for all queued verdicts to be consumed.
  task automatic drain(input string name);
    int budget = 100;
    while ((q1.size() + q4.size() + qs.size()) != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    n_tests++;
    if ((q1.size() + q4.size() + qs.size()) != 0) begin
      n_fail++;
      $display("FAIL %s: verdict not seen, pending=%0d expected 0", name,
               q1.size() + q4.size() + qs.size());
      q1.delete(); q4.delete(); qs.delete();
    end
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state.
    chk("rst_done1", 64'(d1), 64'd0);
    chk("rst_flags1", {p1, f1, t1}, 64'd0);
    chk("rst_cycles1", cy1, 64'd0);
    chk("rst_chan4", 64'(cd4), 64'd0);
    chk("rst_code4", 64'(code4), 64'd0);

    // Single channel pass at edge 7.
    q1.push_back('{pass: 1, fail: 0, tmo: 0, code: 0, chan: 0, cdone: 4'd1, cycles: 64'd7});
    s1 = 1; tick(1); s1 = 0;
    tick(6);
    e1 = 64'h1; tick(1); e1 = '0;
    drain("pass1");

    // Clear returns everything to zero.
    c1 = 1; tick(1); c1 = 0;
    chk("clr_done1", 64'(d1), 64'd0);
    chk("clr_pass1", 64'(p1), 64'd0);
    chk("clr_cycles1", cy1, 64'd0);

    // start_i in RUN does not restart the counter.
    q1.push_back('{pass: 1, fail: 0, tmo: 0, code: 0, chan: 0, cdone: 4'd1, cycles: 64'd5});
    s1 = 1; tick(1); s1 = 0;
    tick(2);
    s1 = 1; tick(1); s1 = 0;
    tick(1);
    e1 = 64'h1; tick(1); e1 = '0;
    drain("start_in_run");

    // clear and start together go to IDLE, no run begins.
    c1 = 1; s1 = 1; tick(1); c1 = 0; s1 = 0;
    tick(3);
    chk("clr_start_cycles", cy1, 64'd0);
    e1 = 64'h1; tick(1); e1 = '0;
    chk("idle_ignores_exit", 64'(cd1), 64'd0);

    // Single channel fail, code 10.
    q1.push_back('{pass: 0, fail: 1, tmo: 0, code: 63'd10, chan: 0, cdone: 4'd1, cycles: 64'd2});
    s1 = 1; tick(1); s1 = 0;
    tick(1);
    e1 = 64'h15; tick(1); e1 = '0;
    drain("fail1");
    c1 = 1; tick(1); c1 = 0;

    // Four channels pass at edges 3, 9, 5, 12; late code on ch0 ignored.
    q4.push_back('{pass: 1, fail: 0, tmo: 0, code: 0, chan: 0, cdone: 4'hF, cycles: 64'd12});
    s4 = 1; tick(1); s4 = 0;
    tick(2);
    e4[0 +: 64] = 64'h1; tick(1);
    chk("cdone_e3", 64'(cd4), 64'b0001);
    e4[0 +: 64] = 64'h9; tick(1); e4 = '0;
    e4[128 +: 64] = 64'h1; tick(1); e4 = '0;
    chk("cdone_e5", 64'(cd4), 64'b0101);
    tick(3);
    e4[64 +: 64] = 64'h1; tick(1); e4 = '0;
    chk("cdone_e9", 64'(cd4), 64'b0111);
    chk("not_done_e9", 64'(d4), 64'd0);
    tick(2);
    e4[192 +: 64] = 64'h1; tick(1); e4 = '0;
    drain("pass4");

    // Simultaneous failures at edge 6: lowest channel (1, code 10) wins.
    c4 = 1; tick(1); c4 = 0;
    q4.push_back('{pass: 0, fail: 1, tmo: 0, code: 63'd10, chan: 4'd1, cdone: 4'b1110, cycles: 64'd6});
    s4 = 1; tick(1); s4 = 0;
    tick(5);
    e4[64 +: 64] = 64'h15;
    e4[128 +: 64] = 64'h7;
    e4[192 +: 64] = 64'h7;
    tick(1); e4 = '0;
    drain("fail4_priority");

    // Watchdog behaviour on u1 (limit 20).
`ifdef ARA_EOC_WATCHDOG_EN
    q1.push_back('{pass: 0, fail: 1, tmo: 1, code: 0, chan: 0, cdone: 4'd0, cycles: 64'd20});
    s1 = 1; tick(1); s1 = 0;
    tick(25);
    drain("watchdog");
`else
    s1 = 1; tick(1); s1 = 0;
    tick(1000);
    chk("no_wd_done", 64'(d1), 64'd0);
    chk("no_wd_cycles", cy1, 64'd1000);
`endif
    c1 = 1; tick(1); c1 = 0;

    // 4-bit counter saturates; exit at edge 20.
    qs.push_back('{pass: 1, fail: 0, tmo: 0, code: 0, chan: 0, cdone: 4'd1, cycles: 64'hF});
    ss = 1; tick(1); ss = 0;
    tick(19);
    es = 64'h1; tick(1); es = '0;
    drain("saturate");

    // Asynchronous reset mid-run.
    cs = 1; tick(1); cs = 0;
    ss = 1; tick(1); ss = 0;
    tick(5);
    chk("pre_rst_cycles", 64'(cys), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cycles", 64'(cys), 64'd0);
    chk("async_rst_done", 64'(ds), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
